// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Drives the single write port of the 32x32 register bank
//                from two producers: the single-cycle ALU writeback stage
//                (priority) and the multicycle mul/div unit (queued in a
//                small FIFO behind a valid/ready handshake). Publishes a
//                pending-destination mask for decode stalls and forces a
//                one-cycle ALU stall so queued results cannot starve.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic        alu_jal,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic [31:0] pending_mask,
    output logic        RegWrite,
    output logic [4:0]  write_register,
    output logic [31:0] write_data
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);
    localparam logic [4:0]         c_LINK_REG = 5'd31;

    // FIFO storage; slot-valid bits let the pending mask be a plain OR
    logic [4:0]         r_fifo_reg  [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [DEPTH-1:0]   r_slot_valid;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_STV_W-1:0] r_starve;
    logic               r_alu_stall;
    logic               r_reg_write;
    logic [4:0]         r_write_register;
    logic [31:0]        r_write_data;

    logic [4:0]         w_alu_dst;
    logic               w_alu_live;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [c_STV_W-1:0] w_starve_next;
    logic [31:0]        w_pending;

    assign w_alu_dst  = alu_jal ? c_LINK_REG : alu_reg;
    // A stalled ALU result is being held upstream and must not be taken yet
    assign w_alu_live = alu_valid & ~r_alu_stall & (w_alu_dst != 5'd0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_pop      = ~w_alu_live & ~w_empty;
    // Zero-destination handshakes complete but carry nothing worth writing
    assign w_push     = md_valid & ~w_full & (md_reg != 5'd0);

    // Next starve count: saturating, cleared by any drain or an empty FIFO
    always_comb begin
        w_starve_next = r_starve;
        if (w_pop || w_empty) begin
            w_starve_next = '0;
        end else if (r_starve != c_LIMIT) begin
            w_starve_next = r_starve + c_STV_W'(1);
        end
    end

    // OR together the one-hot destinations of every occupied slot
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_slot_valid[i]) begin
                w_pending[r_fifo_reg[i]] = 1'b1;
            end
        end
    end

    // Payload storage needs no reset; slot-valid bits qualify its contents
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= md_reg;
            r_fifo_data[r_wr_ptr] <= md_data;
        end
    end

    // FIFO control, starvation guard and registered bank-write outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid     <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_starve         <= '0;
            r_alu_stall      <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= 5'd0;
            r_write_data     <= 32'd0;
        end else begin
            // Push and pop never address the same slot: push needs !full,
            // and pop sharing the write slot would imply full or empty.
            if (w_push) begin
                r_slot_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_slot_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr               <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_starve    <= w_starve_next;
            // The stall cycle always pops, so the counter clears and the
            // stall falls again on the following edge.
            r_alu_stall <= (w_starve_next == c_LIMIT);

            if (w_alu_live) begin
                r_reg_write      <= 1'b1;
                r_write_register <= w_alu_dst;
                r_write_data     <= alu_data;
            end else if (w_pop) begin
                r_reg_write      <= 1'b1;
                r_write_register <= r_fifo_reg[r_rd_ptr];
                r_write_data     <= r_fifo_data[r_rd_ptr];
            end else begin
                r_reg_write      <= 1'b0;
            end
        end
    end

    assign alu_stall      = r_alu_stall;
    assign md_ready       = ~w_full;
    assign pending_mask   = w_pending;
    assign RegWrite       = r_reg_write;
    assign write_register = r_write_register;
    assign write_data     = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter. Stimulus queues
//                expected bank writes; a monitor pops and compares one entry
//                for every cycle the DUT asserts RegWrite.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_jal;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic [31:0] pending_mask;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];

    regfile_write_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_jal        (alu_jal),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .alu_stall      (alu_stall),
        .md_valid       (md_valid),
        .md_ready       (md_ready),
        .md_reg         (md_reg),
        .md_data        (md_data),
        .pending_mask   (pending_mask),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with RegWrite high is exactly one bank write
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {27'd0, write_register}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_reg", {27'd0, write_register}, {27'd0, e.r});
                    chk("wr_data", write_data, e.d);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alu_valid = 1'b0;
        alu_jal   = 1'b0;
        alu_reg   = 5'd0;
        alu_data  = 32'd0;
        md_valid  = 1'b0;
        md_reg    = 5'd0;
        md_data   = 32'd0;

        // Asynchronous reset before any clock edge
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_wreg", {27'd0, write_register}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
        chk("rst_pending", pending_mask, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // ALU only, then JAL link forced to r31
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEAD_BEEF;
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        chk("alu_latency", {31'd0, RegWrite}, 32'd1);
        alu_jal = 1'b1; alu_reg = 5'd7; alu_data = 32'h0040_0008;
        expect_wr(5'd31, 32'h0040_0008);
        tick();
        chk("jal_reg", {27'd0, write_register}, 32'd31);
        alu_valid = 1'b0; alu_jal = 1'b0;
        tick();
        chk("alu_idle", {31'd0, RegWrite}, 32'd0);

        // Mul/div with ALU idle: written to FIFO, drained the next cycle
        chk("md_ready_idle", {31'd0, md_ready}, 32'd1);
        md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h1234_5678;
        expect_wr(5'd9, 32'h1234_5678);
        tick();
        md_valid = 1'b0;
        chk("md_pending", pending_mask, 32'h0000_0200);
        chk("md_not_forwarded", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("md_drain", {31'd0, RegWrite}, 32'd1);
        chk("md_pending_clr", pending_mask, 32'd0);
        tick();

        // Fill the FIFO behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'hA000_0000 + i;
            md_valid  = 1'b1; md_reg  = 5'(i);  md_data  = 32'h0000_1000 + i;
            expect_wr(5'd10, 32'hA000_0000 + i);
            tick();
        end
        // Offer another result while full: must not slip in on the pop edge
        alu_valid = 1'b0;
        md_reg = 5'd20; md_data = 32'h0000_2020;
        chk("full_md_ready", {31'd0, md_ready}, 32'd0);
        chk("full_pending", pending_mask, 32'h0000_001E);
        for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'h0000_1000 + i);
        tick();
        md_valid = 1'b0;
        chk("first_pop_ready", {31'd0, md_ready}, 32'd1);
        chk("no_pop_through", pending_mask, 32'h0000_001C);
        tick();
        tick();
        tick();
        chk("drained_pending", pending_mask, 32'd0);
        tick();
        chk("drained_idle", {31'd0, RegWrite}, 32'd0);

        // Starvation guard: one queued entry behind a continuously busy ALU
        for (int k = 0; k <= 8; k++) begin
            alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'hB000_0000 + k;
            md_valid  = (k == 0); md_reg = 5'd12; md_data = 32'h0000_C0C0;
            expect_wr(5'd11, 32'hB000_0000 + k);
            tick();
            if (k == 7) chk("stall_early", {31'd0, alu_stall}, 32'd0);
            if (k == 8) chk("stall_set", {31'd0, alu_stall}, 32'd1);
        end
        md_valid = 1'b0;
        alu_data = 32'hB000_0009;
        expect_wr(5'd12, 32'h0000_C0C0);
        expect_wr(5'd11, 32'hB000_0009);
        tick();
        chk("stall_pulse", {31'd0, alu_stall}, 32'd0);
        chk("stall_drain_pending", pending_mask, 32'd0);
        tick();
        alu_valid = 1'b0;
        tick();
        chk("starve_idle", {31'd0, RegWrite}, 32'd0);

        // Register zero is never written
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        chk("zero_alu", {31'd0, RegWrite}, 32'd0);
        alu_valid = 1'b0;
        md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h5555_5555;
        chk("zero_md_ready", {31'd0, md_ready}, 32'd1);
        tick();
        md_valid = 1'b0;
        chk("zero_pending", pending_mask, 32'd0);
        chk("zero_md_ready_after", {31'd0, md_ready}, 32'd1);
        tick();
        chk("zero_no_drain", {31'd0, RegWrite}, 32'd0);

        // Reset mid-operation discards the queued entry
        alu_valid = 1'b1; alu_reg = 5'd13; alu_data = 32'hD0D0_D0D0;
        md_valid  = 1'b1; md_reg  = 5'd14; md_data  = 32'h0000_00E0;
        expect_wr(5'd13, 32'hD0D0_D0D0);
        tick();
        alu_valid = 1'b0; md_valid = 1'b0;
        chk("pre_rst_pending", pending_mask, 32'h0000_4000);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("mid_rst_wreg", {27'd0, write_register}, 32'd0);
        chk("mid_rst_wdata", write_data, 32'd0);
        chk("mid_rst_pending", pending_mask, 32'd0);
        chk("mid_rst_ready", {31'd0, md_ready}, 32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, RegWrite}, 32'd0);
        chk("post_rst_pending", pending_mask, 32'd0);
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Write-side driver for the 32x32 register bank.
- Merges two result producers into the bank's single write port: the single-cycle ALU writeback stage, and the multicycle mul/div unit via a valid/ready handshake.
- ALU has priority. Mul/div results are queued in a small FIFO.
- Exposes a pending-destination mask so decode can stall on queued writes, and a starvation guard so queued results always drain.

Parameters:
- DEPTH, 4, mul/div result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles with non-empty FIFO and no drain before an ALU stall is forced (>=1)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU writeback result present this cycle
- alu_jal  input  1  result is a JAL link; destination forced to 31
- alu_reg  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_stall  output  1  registered; upstream must hold the ALU result while high
- md_valid  input  1  mul/div result offered
- md_ready  output  1  FIFO can accept (= !full)
- md_reg  input  5  mul/div destination
- md_data  input  32  mul/div result
- pending_mask  output  32  bit r = 1 while any FIFO entry targets register r
- RegWrite  output  1  registered bank write enable
- write_register  output  5  registered bank write address
- write_data  output  32  registered bank write data

Behaviour:
- Reset (async, reset_n=0): FIFO empty; starve counter 0.
  - RegWrite=0, write_register=0, write_data=0, alu_stall=0, md_ready=1, pending_mask=0.
- Effective ALU destination: 31 if alu_jal, else alu_reg.
- An ALU result is "live" when alu_valid=1, alu_stall=0 and the effective destination is nonzero.
- Selection each rising edge:
  - Live ALU result: latch it to the write outputs with RegWrite=1; FIFO holds.
  - Otherwise, if the FIFO is non-empty: pop the head to the write outputs with RegWrite=1.
  - Otherwise: RegWrite=0; write_register and write_data hold their last values.
- Latency: one cycle, input edge to RegWrite. The bank commits on the following falling edge, so a result is readable within the same cycle it appears on the outputs.
- Register 0 is never written:
  - ALU results targeting 0 are dropped, and the FIFO may drain that cycle.
  - md handshakes with md_reg=0 complete (md_valid & md_ready) but are not pushed.
- Push condition: md_valid & md_ready with md_reg != 0. md_ready = !full, with no pop-through: when full, md_ready=0 even in a cycle that pops.
- Simultaneous push and pop on a non-empty FIFO: both occur and occupancy is unchanged.
- Empty FIFO with a push while the ALU is idle: the entry is written, not forwarded; it drains on the next cycle.
- pending_mask: combinational OR of the one-hot destinations of all valid FIFO entries.
  - Clears in the cycle after the last entry for that register pops.
- Order: FIFO order is preserved. The ALU may overtake queued mul/div results; decode must stall on pending_mask to avoid WAW/RAW hazards. The block does not detect this.
- Starve counter:
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- alu_stall:
  - Set high on the edge where the counter reaches STARVE_LIMIT.
  - While it is high, alu_valid is ignored and the FIFO pops.
  - Falls on the next edge (one-cycle pulse), and the counter clears.
- Reset mid-operation: queued entries are discarded; the bank contents are untouched.

Test Plan:
- Reset with reset_n=0 mid-cycle -> all outputs 0 and md_ready=1 immediately, asynchronously.
- ALU-only: alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF -> next cycle RegWrite=1, write_register=5, write_data=0xDEADBEEF. Then alu_jal=1, alu_reg=7, data 0x00400008 -> write_register=31.
- MD with ALU idle: push reg 9, data 0x12345678 -> pending_mask=0x00000200 next cycle; the cycle after, RegWrite=1 to reg 9 and pending_mask returns to 0.
- Full and ordering (DEPTH=4): hold alu_valid=1; push regs 1,2,3,4 -> md_ready=0 after the 4th push. Drop alu_valid -> pops in order 1,2,3,4 on consecutive cycles, and md_ready=1 after the first pop.
- Starvation (STARVE_LIMIT=8): one queued entry with alu_valid=1 on every cycle -> alu_stall=1 for exactly one cycle after 8 non-drain cycles. The queued entry is written during the stall and the held ALU result is written the following cycle.
- Zero register: alu_reg=0 with alu_valid=1, then md_reg=0 pushed -> RegWrite stays 0, the md handshake completes, and pending_mask stays 0.
